lut_logic_unit_pipe: RTL and testbench

//  Registered, parametrised 2-input bitwise logic unit. Each bit of the result is
//  a 4:1 lookup built from 2:1 mux instances, selected by a programmable 4-bit

---
 rtl/lut_logic_unit_pipe_if.sv | 30 +++
 rtl/lut_logic_unit_pipe.sv | 121 ++++++++++++
 tb/tb_lut_logic_unit_pipe.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/lut_logic_unit_pipe_if.sv
// Stream/config bundle for lut_logic_unit_pipe.
// master = producer/consumer side, slave = the logic unit.
interface lut_logic_unit_pipe_if #(
   parameter int W  = 8,
   parameter int CW = 4
);
   logic          cfg_we;
   logic [3:0]    cfg_tt;
   logic          cfg_acc;
   logic          cfg_busy;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic          in_last;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_y;
   logic [CW-1:0] out_cnt;

   modport master (
      output cfg_we, cfg_tt, cfg_acc, in_valid, in_a, in_b, in_last, out_ready,
      input  cfg_busy, in_ready, out_valid, out_y, out_cnt
   );

   modport slave (
      input  cfg_we, cfg_tt, cfg_acc, in_valid, in_a, in_b, in_last, out_ready,
      output cfg_busy, in_ready, out_valid, out_y, out_cnt
   );
endinterface

// File: rtl/lut_logic_unit_pipe.sv
// Registered 2-input LUT logic unit with valid/ready streaming and an
// accumulate mode that folds a multi-beat stream into a single result.
module lut_logic_unit_pipe #(
   parameter int W  = 8,
   parameter int CW = 4
) (
   input logic                  clk,
   input logic                  rst_n,
   lut_logic_unit_pipe_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

   state_t        state_q, state_d;
   logic [3:0]    tt_q;
   logic          acc_mode_q;
   logic [W-1:0]  acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  y_q, y_d;
   logic [CW-1:0] ycnt_q, ycnt_d;

   logic          accept;
   logic [W-1:0]  x_op;
   logic [W-1:0]  f_val;
   logic [CW-1:0] cnt_inc;

   assign bus.in_ready  = (state_q != HOLD) | bus.out_ready;
   assign bus.out_valid = (state_q == HOLD);
   assign bus.cfg_busy  = (state_q != IDLE);
   assign bus.out_y     = y_q;
   assign bus.out_cnt   = ycnt_q;

   assign accept  = bus.in_valid & bus.in_ready;
   // Only a continuing accumulation feeds back; every first beat uses in_a.
   assign x_op    = (state_q == ACC) ? acc_q : bus.in_a;
   assign cnt_inc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);

   // One LUT slice per result bit.
   for (genvar i = 0; i < W; i++) begin : g_bit
      lut_bit u_bit (
         .tt_i (tt_q),
         .x_i  (x_op[i]),
         .y_i  (bus.in_b[i]),
         .f_o  (f_val[i])
      );
   end

   // Next-state: beat processing, accumulation and result capture.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      y_d     = y_q;
      ycnt_d  = ycnt_q;
      if (accept) begin
         if (!acc_mode_q) begin
            y_d     = f_val;
            ycnt_d  = CW'(1);
            state_d = HOLD;
         end else begin
            acc_d = f_val;
            cnt_d = (state_q == ACC) ? cnt_inc : CW'(1);
            if (bus.in_last) begin
               y_d     = f_val;
               ycnt_d  = cnt_d;
               state_d = HOLD;
            end else begin
               state_d = ACC;
            end
         end
      end else if (state_q == HOLD && bus.out_ready) begin
         state_d = IDLE;
      end
   end

   // State, config and result registers; config only lands while idle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         tt_q       <= 4'b1110;
         acc_mode_q <= 1'b0;
         acc_q      <= '0;
         cnt_q      <= '0;
         y_q        <= '0;
         ycnt_q     <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         y_q     <= y_d;
         ycnt_q  <= ycnt_d;
         if (bus.cfg_we && state_q == IDLE) begin
            tt_q       <= bus.cfg_tt;
            acc_mode_q <= bus.cfg_acc;
         end
      end
   end
endmodule

// One result bit: 4:1 lookup as two mux levels, first on y then on x.
module lut_bit (
   input  logic [3:0] tt_i,
   input  logic       x_i,
   input  logic       y_i,
   output logic       f_o
);
   logic lo, hi;

   lut_mux2 u_lo  (.d0_i(tt_i[0]), .d1_i(tt_i[1]), .sel_i(y_i), .y_o(lo));
   lut_mux2 u_hi  (.d0_i(tt_i[2]), .d1_i(tt_i[3]), .sel_i(y_i), .y_o(hi));
   lut_mux2 u_out (.d0_i(lo),      .d1_i(hi),      .sel_i(x_i), .y_o(f_o));
endmodule

// Plain 2:1 mux.
module lut_mux2 (
   input  logic d0_i,
   input  logic d1_i,
   input  logic sel_i,
   output logic y_o
);
   assign y_o = sel_i ? d1_i : d0_i;
endmodule

// File: tb/tb_lut_logic_unit_pipe.sv
// Randomised self-checking bench for lut_logic_unit_pipe (W=8, CW=4 main
// instance; second instance with CW=2 for counter saturation).
module tb_lut_logic_unit_pipe;
   logic clk = 0;
   logic rst_n = 0;
   int   total = 0;
   int   bad = 0;

   logic [3:0] m_tt;
   logic       m_acc;

   lut_logic_unit_pipe_if #(.W(8), .CW(4)) bus ();
   lut_logic_unit_pipe_if #(.W(8), .CW(2)) bus2 ();

   lut_logic_unit_pipe #(.W(8), .CW(4)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
   lut_logic_unit_pipe #(.W(8), .CW(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

   always #5 clk = ~clk;

   // Sum of minterms: each truth-table bit enables the positions where
   // the operand pair matches that index.
   function automatic logic [7:0] f_ref(input logic [3:0] tt, input logic [7:0] x, input logic [7:0] y);
      return ({8{tt[0]}} & ~x & ~y) | ({8{tt[1]}} & ~x & y) |
             ({8{tt[2]}} &  x & ~y) | ({8{tt[3]}} &  x & y);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.cfg_we = 0; bus.cfg_tt = 0; bus.cfg_acc = 0; bus.in_valid = 0;
      bus.in_a = 0; bus.in_b = 0; bus.in_last = 0; bus.out_ready = 0;
      bus2.cfg_we = 0; bus2.cfg_tt = 0; bus2.cfg_acc = 0; bus2.in_valid = 0;
      bus2.in_a = 0; bus2.in_b = 0; bus2.in_last = 0; bus2.out_ready = 0;
   endtask

   // Config write on the main instance; caller guarantees it is idle.
   task automatic cfg(input logic [3:0] tt, input logic acc);
      bus.cfg_we = 1; bus.cfg_tt = tt; bus.cfg_acc = acc;
      tick();
      bus.cfg_we = 0;
      m_tt = tt; m_acc = acc;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 0;
      tick(); tick();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.out_valid); end
      total++; if (bus.out_y !== 8'h00) begin bad++; $display("FAIL reset_y got=%h want=00", bus.out_y); end
      total++; if (bus.out_cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", bus.out_cnt); end
      total++; if (bus.cfg_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.cfg_busy); end
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.in_ready); end
      rst_n = 1;
      m_tt = 4'b1110; m_acc = 0;
      // Default table is OR.
      bus.in_a = 8'hA0; bus.in_b = 8'h05; bus.in_valid = 1; bus.out_ready = 1;
      tick();
      bus.in_valid = 0;
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL first_valid got=%b want=1", bus.out_valid); end
      total++; if (bus.out_y !== 8'hA5) begin bad++; $display("FAIL first_y got=%h want=a5", bus.out_y); end
      total++; if (bus.out_cnt !== 4'd1) begin bad++; $display("FAIL first_cnt got=%0d want=1", bus.out_cnt); end
      total++; if (bus.cfg_busy !== 1'b1) begin bad++; $display("FAIL first_busy got=%b want=1", bus.cfg_busy); end
      tick();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL drain_valid got=%b want=0", bus.out_valid); end
      total++; if (bus.cfg_busy !== 1'b0) begin bad++; $display("FAIL drain_busy got=%b want=0", bus.cfg_busy); end
   endtask

   task automatic test_direct();
      logic [3:0] tts [4] = '{4'b1000, 4'b0110, 4'b0000, 4'b1111};
      logic [7:0] a, b;
      // Fixed tables on F0/3C, then random tables and operands.
      for (int i = 0; i < 24; i++) begin
         if (i < 4) begin cfg(tts[i], 0); a = 8'hF0; b = 8'h3C; end
         else begin cfg(4'($urandom), 0); a = 8'($urandom); b = 8'($urandom); end
         bus.in_a = a; bus.in_b = b; bus.in_valid = 1; bus.out_ready = 1;
         tick();
         bus.in_valid = 0;
         total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL direct_valid[%0d] got=%b want=1", i, bus.out_valid); end
         total++; if (bus.out_y !== f_ref(m_tt, a, b)) begin bad++; $display("FAIL direct_y[%0d] tt=%b got=%h want=%h", i, m_tt, bus.out_y, f_ref(m_tt, a, b)); end
         total++; if (bus.out_cnt !== 4'd1) begin bad++; $display("FAIL direct_cnt[%0d] got=%0d want=1", i, bus.out_cnt); end
         tick();
      end
      // Config write alongside a beat: the beat sees the old table.
      cfg(4'b1110, 0);
      bus.cfg_we = 1; bus.cfg_tt = 4'b1000; bus.cfg_acc = 0;
      bus.in_a = 8'hA0; bus.in_b = 8'h05; bus.in_valid = 1;
      tick();
      bus.cfg_we = 0; bus.in_valid = 0; m_tt = 4'b1000;
      total++; if (bus.out_y !== 8'hA5) begin bad++; $display("FAIL cfg_same_cycle got=%h want=a5", bus.out_y); end
      tick();
      bus.in_a = 8'hF0; bus.in_b = 8'h3C; bus.in_valid = 1;
      tick();
      bus.in_valid = 0;
      total++; if (bus.out_y !== 8'h30) begin bad++; $display("FAIL cfg_applied got=%h want=30", bus.out_y); end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [7:0] a [8];
      logic [7:0] b [8];
      cfg(4'b1110, 0);
      bus.in_a = 8'h5A; bus.in_b = 8'h00; bus.in_valid = 1; bus.out_ready = 0;
      tick();
      bus.in_a = 8'hFF; bus.in_b = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL hold_ready[%0d] got=%b want=0", i, bus.in_ready); end
         total++; if (bus.out_valid !== 1'b1 || bus.out_y !== 8'h5A) begin bad++; $display("FAIL hold_y[%0d] got=%b/%h want=1/5a", i, bus.out_valid, bus.out_y); end
         tick();
      end
      bus.out_ready = 1;
      for (int i = 0; i < 8; i++) begin
         a[i] = 8'($urandom); b[i] = 8'($urandom);
         bus.in_a = a[i]; bus.in_b = b[i];
         tick();
         total++; if (bus.out_valid !== 1'b1 || bus.out_y !== f_ref(m_tt, a[i], b[i])) begin bad++; $display("FAIL b2b[%0d] got=%b/%h want=1/%h", i, bus.out_valid, bus.out_y, f_ref(m_tt, a[i], b[i])); end
      end
      bus.in_valid = 0;
      tick();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b want=0", bus.out_valid); end
   endtask

   task automatic test_accumulate();
      logic [7:0] a, b, acc;
      int n, cnt;
      // Fixed OR-reduce example.
      cfg(4'b1110, 1);
      bus.out_ready = 1;
      bus.in_a = 8'h01; bus.in_b = 8'h02; bus.in_last = 0; bus.in_valid = 1;
      tick();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL acc_early0 got=%b want=0", bus.out_valid); end
      bus.in_a = 8'hEE; bus.in_b = 8'h04;
      tick();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL acc_early1 got=%b want=0", bus.out_valid); end
      bus.in_b = 8'h80; bus.in_last = 1;
      tick();
      bus.in_valid = 0; bus.in_last = 0;
      total++; if (bus.out_valid !== 1'b1 || bus.out_y !== 8'h87 || bus.out_cnt !== 4'd3) begin bad++; $display("FAIL acc_or got=%b/%h/%0d want=1/87/3", bus.out_valid, bus.out_y, bus.out_cnt); end
      tick();
      // Random tables, lengths up to past saturation, random gaps, streams back to back.
      cfg(4'($urandom), 1);
      for (int s = 0; s < 6; s++) begin
         n = $urandom_range(1, 20);
         acc = 0;
         for (int k = 0; k < n; k++) begin
            if (k > 0 && $urandom_range(0, 2) == 0) begin
               bus.in_valid = 0;
               tick();
               total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL acc_gap[%0d.%0d] got=%b want=0", s, k, bus.out_valid); end
            end
            a = 8'($urandom); b = 8'($urandom);
            acc = (k == 0) ? f_ref(m_tt, a, b) : f_ref(m_tt, acc, b);
            bus.in_a = a; bus.in_b = b; bus.in_valid = 1; bus.in_last = (k == n - 1);
            tick();
            if (k < n - 1) begin
               total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL acc_mid[%0d.%0d] got=%b want=0", s, k, bus.out_valid); end
            end
         end
         cnt = (n > 15) ? 15 : n;
         total++; if (bus.out_valid !== 1'b1 || bus.out_y !== acc || bus.out_cnt !== 4'(cnt)) begin bad++; $display("FAIL acc_res[%0d] n=%0d got=%b/%h/%0d want=1/%h/%0d", s, n, bus.out_valid, bus.out_y, bus.out_cnt, acc, cnt); end
      end
      bus.in_valid = 0; bus.in_last = 0;
      tick();
   endtask

   task automatic test_cfg_busy();
      cfg(4'b1110, 1);
      bus.out_ready = 1;
      bus.in_a = 8'h01; bus.in_b = 8'h02; bus.in_last = 0; bus.in_valid = 1;
      tick();
      bus.cfg_we = 1; bus.cfg_tt = 4'b1000; bus.cfg_acc = 0;
      bus.in_b = 8'h04;
      tick();
      bus.cfg_we = 0;
      bus.in_valid = 0;
      tick();
      total++; if (bus.cfg_busy !== 1'b1 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL acc_stall got=%b/%b want=1/0", bus.cfg_busy, bus.out_valid); end
      bus.in_b = 8'h80; bus.in_last = 1; bus.in_valid = 1;
      tick();
      bus.in_valid = 0; bus.in_last = 0;
      total++; if (bus.out_y !== 8'h87 || bus.out_cnt !== 4'd3) begin bad++; $display("FAIL busy_cfg_drop got=%h/%0d want=87/3", bus.out_y, bus.out_cnt); end
      tick();
      // Reset in the middle of an accumulation.
      bus.in_a = 8'h0F; bus.in_b = 8'h10; bus.in_valid = 1;
      tick();
      bus.in_valid = 0;
      rst_n = 0;
      tick();
      rst_n = 1;
      m_tt = 4'b1110; m_acc = 0;
      total++; if (bus.out_valid !== 1'b0 || bus.cfg_busy !== 1'b0) begin bad++; $display("FAIL midreset got=%b/%b want=0/0", bus.out_valid, bus.cfg_busy); end
      bus.in_a = 8'hA0; bus.in_b = 8'h05; bus.in_valid = 1;
      tick();
      bus.in_valid = 0;
      total++; if (bus.out_valid !== 1'b1 || bus.out_y !== 8'hA5 || bus.out_cnt !== 4'd1) begin bad++; $display("FAIL midreset_or got=%b/%h/%0d want=1/a5/1", bus.out_valid, bus.out_y, bus.out_cnt); end
      tick();
   endtask

   task automatic test_saturate();
      logic [3:0] tt;
      logic [7:0] a, b, acc;
      int lens [2] = '{5, 2};
      tt = 4'($urandom);
      bus2.cfg_we = 1; bus2.cfg_tt = tt; bus2.cfg_acc = 1;
      tick();
      bus2.cfg_we = 0; bus2.out_ready = 1;
      for (int s = 0; s < 2; s++) begin
         acc = 0;
         for (int k = 0; k < lens[s]; k++) begin
            a = 8'($urandom); b = 8'($urandom);
            acc = (k == 0) ? f_ref(tt, a, b) : f_ref(tt, acc, b);
            bus2.in_a = a; bus2.in_b = b; bus2.in_valid = 1; bus2.in_last = (k == lens[s] - 1);
            tick();
         end
         bus2.in_valid = 0; bus2.in_last = 0;
         total++; if (bus2.out_valid !== 1'b1 || bus2.out_y !== acc || bus2.out_cnt !== 2'(lens[s] > 3 ? 3 : lens[s])) begin bad++; $display("FAIL sat[%0d] got=%b/%h/%0d want=1/%h/%0d", s, bus2.out_valid, bus2.out_y, bus2.out_cnt, acc, (lens[s] > 3 ? 3 : lens[s])); end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_direct();
      test_back_to_back();
      test_accumulate();
      test_cfg_busy();
      test_saturate();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
